// File: rtl/scale_mul_arbiter_pkg.sv
// Shared constants and helpers for the amplitude-scaling multiplier scheduler.
// Defaults describe a 4-channel Q1.7 configuration.
package scale_mul_arbiter_pkg;

  localparam int N_FRAC_DEF = 7;
  localparam int N_CH_DEF   = 4;
  localparam int SMP_W_DEF  = N_FRAC_DEF + 1;

  // Width of a channel index; a 1-channel build still carries one index bit.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // LSB of channel c inside a packed per-channel bus of w-bit fields.
  function automatic int slice_lo(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/scale_mul_arbiter_rr.sv
// Round-robin grant search over a pending vector.
// The rotating priority pointer lives here and advances past each granted channel.
module scale_mul_arbiter_rr
  import scale_mul_arbiter_pkg::*;
#(
  parameter  int N_CH  = N_CH_DEF,
  localparam int IDX_W = ch_idx_w(N_CH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  pending_i,
  output logic [N_CH-1:0]  grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // N_CH is a power of two, so the index adder wraps exactly at N_CH.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_cand = r_ptr + IDX_W'(i);
      if (!w_found && pending_i[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_idx + IDX_W'(1);
    end
  end

  assign grant_vld_o = w_found;
  assign grant_idx_o = w_idx;
  assign grant_o     = w_found ? (N_CH'(1) << w_idx) : '0;

endmodule

// File: rtl/scale_mul_arbiter.sv
// Shares one signed Q1.N_FRAC amplitude multiplier among N_CH channel generators.
// One pending request is buffered per channel; results come out tagged with the channel index.
module scale_mul_arbiter
  import scale_mul_arbiter_pkg::*;
#(
  parameter  int N_FRAC = N_FRAC_DEF,
  parameter  int N_CH   = N_CH_DEF,
  localparam int SMP_W  = N_FRAC + 1,
  localparam int IDX_W  = ch_idx_w(N_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_CH-1:0]         req_strobe_i,
  input  logic [N_CH*SMP_W-1:0]   sample_i,
  input  logic [N_CH*SMP_W-1:0]   amplitude_i,
  input  logic                    clear_overrun_i,
  output logic [SMP_W-1:0]        data_o,
  output logic [IDX_W-1:0]        channel_o,
  output logic                    data_out_valid_strobe_o,
  output logic [N_CH-1:0]         pending_o,
  output logic [N_CH-1:0]         overrun_o
);

  localparam int PROD_W = 2 * SMP_W;

  // Keep product bits [2*N_FRAC:N_FRAC]; the sign bit above is dropped, so -1 * -1 wraps to -1.
  function automatic logic signed [SMP_W-1:0] trunc_q(input logic signed [PROD_W-1:0] p);
    return p[2*N_FRAC:N_FRAC];
  endfunction

  logic signed [SMP_W-1:0] r_hold_smp [N_CH];
  logic signed [SMP_W-1:0] r_hold_amp [N_CH];
  logic [N_CH-1:0]         r_pending;
  logic [N_CH-1:0]         r_overrun;

  logic signed [SMP_W-1:0] r_opa_p0;
  logic signed [SMP_W-1:0] r_opb_p0;
  logic [IDX_W-1:0]        r_ch_p0;
  logic                    r_vld_p0;

  logic signed [SMP_W-1:0] r_data_p1;
  logic [IDX_W-1:0]        r_ch_p1;
  logic                    r_vld_p1;

  logic [N_CH-1:0]         w_grant;
  logic [IDX_W-1:0]        w_grant_idx;
  logic                    w_grant_vld;
  logic [N_CH-1:0]         w_ovr_set;
  logic signed [PROD_W-1:0] w_a_ext;
  logic signed [PROD_W-1:0] w_b_ext;
  logic signed [PROD_W-1:0] w_prod;

  scale_mul_arbiter_rr #(
    .N_CH        (N_CH)
  ) u_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pending_i   (r_pending),
    .grant_o     (w_grant),
    .grant_idx_o (w_grant_idx),
    .grant_vld_o (w_grant_vld)
  );

  // A strobe on the channel being granted this cycle is a fresh request, not an overrun.
  assign w_ovr_set = req_strobe_i & r_pending & ~w_grant;

  // Holding registers and operands: operands read the pre-edge holding value.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < N_CH; c++) begin
      if (req_strobe_i[c]) begin
        r_hold_smp[c] <= sample_i[slice_lo(c, SMP_W) +: SMP_W];
        r_hold_amp[c] <= amplitude_i[slice_lo(c, SMP_W) +: SMP_W];
      end
    end
    if (w_grant_vld) begin
      r_opa_p0 <= r_hold_smp[w_grant_idx];
      r_opb_p0 <= r_hold_amp[w_grant_idx];
    end
  end

  // Stage p0 -> p1: signed multiply of the granted operands.
  assign w_a_ext = {{SMP_W{r_opa_p0[SMP_W-1]}}, r_opa_p0};
  assign w_b_ext = {{SMP_W{r_opb_p0[SMP_W-1]}}, r_opb_p0};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pending <= '0;
      r_overrun <= '0;
      r_vld_p0  <= 1'b0;
      r_ch_p0   <= '0;
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_ch_p1   <= '0;
    end else begin
      r_pending <= req_strobe_i | (r_pending & ~w_grant);
      r_overrun <= w_ovr_set | (clear_overrun_i ? '0 : r_overrun);
      r_vld_p0  <= w_grant_vld;
      if (w_grant_vld) begin
        r_ch_p0 <= w_grant_idx;
      end
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0) begin
        r_data_p1 <= trunc_q(w_prod);
        r_ch_p1   <= r_ch_p0;
      end
    end
  end

  assign data_o                  = r_data_p1;
  assign channel_o               = r_ch_p1;
  assign data_out_valid_strobe_o = r_vld_p1;
  assign pending_o               = r_pending;
  assign overrun_o               = r_overrun;

endmodule

// File: tb/tb_scale_mul_arbiter.sv
// Directed plus randomized bench for scale_mul_arbiter against a queue/array reference model.
module tb_scale_mul_arbiter;

  localparam int NF = 7;
  localparam int NC = 4;
  localparam int SW = NF + 1;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [NC-1:0]    req_strobe_i;
  logic [NC*SW-1:0] sample_i;
  logic [NC*SW-1:0] amplitude_i;
  logic             clear_overrun_i;
  logic [SW-1:0]    data_o;
  logic [IW-1:0]    channel_o;
  logic             data_out_valid_strobe_o;
  logic [NC-1:0]    pending_o;
  logic [NC-1:0]    overrun_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [SW-1:0] m_hs [NC];
  logic [SW-1:0] m_ha [NC];
  logic [NC-1:0] m_pend;
  logic [NC-1:0] m_ovr;
  int            m_ptr;
  bit            m_opv;
  logic [SW-1:0] m_opa, m_opb;
  int            m_opch;
  bit            m_outv;
  logic [SW-1:0] m_out;
  int            m_outch;

  always #5 clk = ~clk;

  scale_mul_arbiter #(.N_FRAC(NF), .N_CH(NC)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst_i),
    .req_strobe_i            (req_strobe_i),
    .sample_i                (sample_i),
    .amplitude_i             (amplitude_i),
    .clear_overrun_i         (clear_overrun_i),
    .data_o                  (data_o),
    .channel_o               (channel_o),
    .data_out_valid_strobe_o (data_out_valid_strobe_o),
    .pending_o               (pending_o),
    .overrun_o               (overrun_o)
  );

  // Q1.NF product with truncation toward minus infinity, wrapped to SW bits.
  function automatic logic [SW-1:0] q_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    p = p >>> NF;
    return p[SW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_ovr   = '0;
    m_ptr   = 0;
    m_opv   = 0;
    m_outv  = 0;
    m_out   = '0;
    m_outch = 0;
  endtask

  task automatic model_edge();
    int g;
    if (m_opv) begin
      m_out   = q_mul(m_opa, m_opb);
      m_outch = m_opch;
    end
    m_outv = m_opv;
    g = -1;
    for (int i = 0; i < NC; i++) begin
      int c;
      c = (m_ptr + i) % NC;
      if (g < 0 && m_pend[c]) g = c;
    end
    m_opv = (g >= 0);
    if (g >= 0) begin
      m_opa     = m_hs[g];
      m_opb     = m_ha[g];
      m_opch    = g;
      m_ptr     = (g + 1) % NC;
      m_pend[g] = 1'b0;
    end
    if (clear_overrun_i) m_ovr = '0;
    for (int c = 0; c < NC; c++) begin
      if (req_strobe_i[c]) begin
        if (m_pend[c]) m_ovr[c] = 1'b1;
        m_pend[c] = 1'b1;
        m_hs[c]   = sample_i[c*SW +: SW];
        m_ha[c]   = amplitude_i[c*SW +: SW];
      end
    end
  endtask

  task automatic check_all();
    chk("valid",   32'(data_out_valid_strobe_o), 32'(m_outv));
    chk("channel", 32'(channel_o), m_outch);
    chk("data",    32'(data_o), 32'(m_out));
    chk("pending", 32'(pending_o), 32'(m_pend));
    chk("overrun", 32'(overrun_o), 32'(m_ovr));
  endtask

  task automatic set_ch(input int c, input logic [SW-1:0] s, input logic [SW-1:0] a);
    sample_i[c*SW +: SW]    = s;
    amplitude_i[c*SW +: SW] = a;
  endtask

  task automatic cycle(input logic [NC-1:0] stb, input bit clr);
    req_strobe_i    = stb;
    clear_overrun_i = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic corner(input logic [SW-1:0] s, input logic [SW-1:0] a, input logic [SW-1:0] e);
    set_ch(0, s, a);
    cycle(4'b0001, 0);
    cycle(4'b0000, 0);
    cycle(4'b0000, 0);
    chk("corner_vld",  32'(data_out_valid_strobe_o), 1);
    chk("corner_data", 32'(data_o), 32'(e));
    cycle(4'b0000, 0);
  endtask

  initial begin
    rst_i           = 1'b0;
    req_strobe_i    = '0;
    sample_i        = '0;
    amplitude_i     = '0;
    clear_overrun_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    check_all();

    // Single request on channel 2
    set_ch(2, 8'h40, 8'h40);
    cycle(4'b0100, 0);
    chk("single_pend", 32'(pending_o), 32'h4);
    cycle(4'b0000, 0);
    cycle(4'b0000, 0);
    chk("single_vld",  32'(data_out_valid_strobe_o), 1);
    chk("single_data", 32'(data_o), 32'h20);
    chk("single_ch",   32'(channel_o), 2);
    cycle(4'b0000, 0);
    chk("single_pulse_end", 32'(data_out_valid_strobe_o), 0);
    chk("single_hold", 32'(data_o), 32'h20);

    // Arithmetic corners
    corner(8'h80, 8'h80, 8'h80);
    corner(8'h7F, 8'h7F, 8'h7E);
    corner(8'hC0, 8'h40, 8'hE0);

    // Asynchronous reset in the middle of a burst
    for (int c = 0; c < NC; c++) set_ch(c, 8'(c * 16 + 5), 8'h60);
    cycle(4'b1111, 0);
    cycle(4'b0000, 0);
    cycle(4'b0000, 0);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_vld",     32'(data_out_valid_strobe_o), 0);
    chk("rst_data",    32'(data_o), 0);
    chk("rst_ch",      32'(channel_o), 0);
    chk("rst_pending", 32'(pending_o), 0);
    chk("rst_overrun", 32'(overrun_o), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    repeat (3) cycle(4'b0000, 0);
    chk("post_rst_quiet", 32'(data_out_valid_strobe_o), 0);

    // All four channels together, pointer at 0
    for (int c = 0; c < NC; c++) set_ch(c, 8'($urandom), 8'($urandom));
    cycle(4'b1111, 0);
    cycle(4'b0000, 0);
    for (int k = 0; k < NC; k++) begin
      cycle(4'b0000, 0);
      chk("burst_vld", 32'(data_out_valid_strobe_o), 1);
      chk("burst_ch",  32'(channel_o), k);
    end
    for (int c = 0; c < NC; c++) set_ch(c, 8'($urandom), 8'($urandom));
    cycle(4'b1111, 0);
    cycle(4'b0000, 0);
    cycle(4'b0000, 0);
    chk("burst2_first", 32'(channel_o), 0);
    repeat (4) cycle(4'b0000, 0);

    // Overrun on channel 1 while channel 0 takes the first grant
    set_ch(0, 8'h40, 8'h20);
    set_ch(1, 8'h11, 8'h22);
    cycle(4'b0011, 0);
    set_ch(1, 8'h33, 8'h44);
    cycle(4'b0010, 0);
    chk("ovr_set", 32'(overrun_o[1]), 1);
    cycle(4'b0000, 0);
    chk("ovr_first_ch", 32'(channel_o), 0);
    cycle(4'b0000, 0);
    chk("ovr_ch",   32'(channel_o), 1);
    chk("ovr_data", 32'(data_o), 32'h1B);
    cycle(4'b0000, 0);
    chk("ovr_single_out", 32'(data_out_valid_strobe_o), 0);
    cycle(4'b0000, 1);
    chk("ovr_clear", 32'(overrun_o[1]), 0);

    // Strobe on channel 3 in the cycle it is granted
    set_ch(3, 8'h10, 8'h40);
    cycle(4'b1000, 0);
    set_ch(3, 8'h20, 8'h40);
    cycle(4'b1000, 0);
    chk("sg_pend", 32'(pending_o[3]), 1);
    chk("sg_ovr",  32'(overrun_o[3]), 0);
    cycle(4'b0000, 0);
    chk("sg_old_ch",   32'(channel_o), 3);
    chk("sg_old_data", 32'(data_o), 32'h08);
    cycle(4'b0000, 0);
    chk("sg_new_vld",  32'(data_out_valid_strobe_o), 1);
    chk("sg_new_data", 32'(data_o), 32'h10);
    chk("sg_ovr_end",  32'(overrun_o[3]), 0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [NC-1:0] stb;
      for (int c = 0; c < NC; c++) begin
        set_ch(c, 8'($urandom), 8'($urandom));
        stb[c] = ($urandom_range(0, 2) == 0);
      end
      cycle(stb, $urandom_range(0, 15) == 0);
    end
    repeat (10) cycle(4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
